// File: rtl/frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its environment: pixel
// streams in and out, processing-controller launch/complete, and the RAM port.
interface frame_sequencer_if;
    logic        go;
    logic [8:0]  dim;
    logic [7:0]  pix_in;
    logic        pix_in_valid;
    logic        pix_in_ready;
    logic        ready;
    logic        start;
    logic        mem_own;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_out;
    logic        pix_out_valid;
    logic        pix_out_ready;
    logic        busy;
    logic        frame_done;

    modport slave (
        input  go, dim, pix_in, pix_in_valid, start, mem_rdata, pix_out_ready,
        output pix_in_ready, ready, mem_own, mem_addr, mem_we, mem_wdata,
               pix_out, pix_out_valid, busy, frame_done
    );

    modport master (
        output go, dim, pix_in, pix_in_valid, start, mem_rdata, pix_out_ready,
        input  pix_in_ready, ready, mem_own, mem_addr, mem_we, mem_wdata,
               pix_out, pix_out_valid, busy, frame_done
    );
endinterface

// File: rtl/frame_sequencer.sv
// Loads a dim x dim frame into RAM, hands it to the processing controller,
// then streams the processed frame back out one pixel per two cycles.
module frame_sequencer #(
    parameter int MAX_DIM = 28
) (
    input logic              clk,
    input logic              rst_n,
    frame_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, LAUNCH, WAIT, UNLOAD_RD, UNLOAD_OUT
    } state_t;

    localparam logic [8:0] MAX_DIM_L = 9'(MAX_DIM);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] total_q, total_d;
    logic [7:0]  pix_out_q, pix_out_d;
    logic        hold_q, hold_d;
    logic        last;

    // Oversized requests saturate to MAX_DIM rather than being rejected.
    function automatic logic [15:0] frame_total(input logic [8:0] d);
        logic [8:0]  c;
        logic [15:0] w;
        c = (d > MAX_DIM_L) ? MAX_DIM_L : d;
        w = {7'd0, c};
        return w * w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            total_q   <= '0;
            pix_out_q <= '0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            total_q   <= total_d;
            pix_out_q <= pix_out_d;
            hold_q    <= hold_d;
        end
    end

    assign last = (addr_q == total_q - 16'd1);

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        total_d            = total_q;
        pix_out_d          = pix_out_q;
        hold_d             = (state_q == UNLOAD_OUT);
        bus.pix_in_ready   = 1'b0;
        bus.ready          = 1'b1;
        bus.mem_own        = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_we         = 1'b0;
        bus.mem_wdata      = '0;
        bus.pix_out        = pix_out_q;
        bus.pix_out_valid  = 1'b0;
        bus.frame_done     = 1'b0;
        bus.busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.go && (bus.dim != 9'd0)) begin
                    total_d = frame_total(bus.dim);
                    addr_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.pix_in_ready = 1'b1;
                bus.mem_own      = 1'b1;
                bus.mem_addr     = addr_q;
                if (bus.pix_in_valid) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = bus.pix_in;
                    addr_d        = addr_q + 16'd1;
                    if (last) state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.ready = 1'b0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (bus.start) begin
                    addr_d  = '0;
                    state_d = UNLOAD_RD;
                end
            end
            UNLOAD_RD: begin
                bus.mem_own  = 1'b1;
                bus.mem_addr = addr_q;
                state_d      = UNLOAD_OUT;
            end
            UNLOAD_OUT: begin
                // RAM data lands in the first cycle here: pass it through once, then hold the register.
                bus.mem_own       = 1'b1;
                bus.mem_addr      = addr_q;
                bus.pix_out_valid = 1'b1;
                if (!hold_q) begin
                    pix_out_d   = bus.mem_rdata;
                    bus.pix_out = bus.mem_rdata;
                end
                if (bus.pix_out_ready) begin
                    if (last) begin
                        bus.frame_done = 1'b1;
                        state_d        = IDLE;
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        state_d = UNLOAD_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a one-cycle-latency RAM model.
module tb_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    frame_sequencer_if bus();
    frame_sequencer #(.MAX_DIM(28)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  ram [0:65535];
    int          wr_cnt = 0;
    logic [15:0] last_wr_addr = '0;
    int          own_viol = 0;
    int          ready_low_cnt = 0;
    int          fd_cnt = 0;
    logic [7:0]  got_q [$];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            wr_cnt++;
            last_wr_addr = bus.mem_addr;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (bus.mem_own === 1'b0 && (bus.mem_addr !== 16'd0 || bus.mem_we !== 1'b0)) own_viol++;
        if (bus.ready === 1'b0) ready_low_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, output bit done);
        got_q.delete();
        done = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pix_out_ready = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            if (bus.pix_out_valid) got_q.push_back(bus.pix_out);
            if (bus.frame_done) done = 1'b1;
            step();
        end
    endtask

    task automatic load_frame(input logic [8:0] d, input logic [7:0] base, input int n);
        bus.go = 1'b1;
        bus.dim = d;
        step();
        bus.go = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.pix_in = base + 8'(i);
            bus.pix_in_valid = 1'b1;
            step();
        end
        bus.pix_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.go = 1'b1; bus.dim = 9'd2; bus.start = 1'b1; bus.pix_in_valid = 1'b1;
        bus.pix_in = 8'h55; bus.pix_out_ready = 1'b1;
        rst_n = 1'b1;
        step(); step();
        total_cnt++;
        if ({bus.pix_in_ready, bus.ready, bus.mem_own, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.pix_out_valid, bus.busy, bus.frame_done} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got ird=%b rdy=%b own=%b we=%b addr=%h wd=%h pv=%b busy=%b fd=%b",
                     bus.pix_in_ready, bus.ready, bus.mem_own, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                     bus.pix_out_valid, bus.busy, bus.frame_done);
        else pass_cnt++;
        total_cnt++;
        if (bus.pix_out !== 8'h00) $display("FAIL reset_pix_out: got %h want 00", bus.pix_out);
        else pass_cnt++;
        bus.go = 1'b0; bus.start = 1'b0; bus.pix_in_valid = 1'b0; bus.pix_out_ready = 1'b0;
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_load();
        logic [7:0] vals [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int rl0;
        bus.go = 1'b1; bus.dim = 9'd2;
        step();
        bus.go = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b1 || bus.pix_in_ready !== 1'b1)
            $display("FAIL load_entry: busy=%b ird=%b want 1 1", bus.busy, bus.pix_in_ready);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus.pix_in = vals[i];
            bus.pix_in_valid = 1'b1;
            #1;
            total_cnt++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'(i) || bus.mem_wdata !== vals[i])
                $display("FAIL load_write%0d: we=%b addr=%0d wd=%0d want 1 %0d %0d",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, i, vals[i]);
            else pass_cnt++;
            step();
        end
        bus.pix_in_valid = 1'b0;
        rl0 = ready_low_cnt;
        total_cnt++;
        if (bus.ready !== 1'b0 || bus.mem_own !== 1'b0 || bus.pix_in_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL launch: rdy=%b own=%b ird=%b busy=%b want 0 0 0 1",
                     bus.ready, bus.mem_own, bus.pix_in_ready, bus.busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.ready !== 1'b1 || ready_low_cnt - rl0 !== 1)
            $display("FAIL ready_pulse: rdy=%b low_cycles=%0d want 1 1", bus.ready, ready_low_cnt - rl0);
        else pass_cnt++;
        total_cnt++;
        if ({ram[0], ram[1], ram[2], ram[3]} !== {8'd10, 8'd20, 8'd30, 8'd40})
            $display("FAIL ram_contents: got %0d %0d %0d %0d want 10 20 30 40", ram[0], ram[1], ram[2], ram[3]);
        else pass_cnt++;
        // a go while waiting for the controller must not restart loading
        bus.go = 1'b1; bus.dim = 9'd3;
        step();
        bus.go = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b1 || bus.pix_in_ready !== 1'b0 || bus.ready !== 1'b1 || bus.mem_own !== 1'b0)
            $display("FAIL wait_go_ignored: busy=%b ird=%b rdy=%b own=%b want 1 0 1 0",
                     bus.busy, bus.pix_in_ready, bus.ready, bus.mem_own);
        else pass_cnt++;
    endtask

    task automatic test_unload();
        logic [7:0] exp [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        int fd0;
        fd0 = fd_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pix_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (bus.mem_own !== 1'b1 || bus.mem_addr !== 16'(i) || bus.pix_out_valid !== 1'b0)
                $display("FAIL unload_rd%0d: own=%b addr=%0d pv=%b want 1 %0d 0",
                         i, bus.mem_own, bus.mem_addr, bus.pix_out_valid, i);
            else pass_cnt++;
            if (i == 2) bus.pix_out_ready = 1'b0;
            step();
            if (i == 2) begin
                for (int k = 0; k < 5; k++) begin
                    total_cnt++;
                    if (bus.pix_out !== 8'd30 || bus.pix_out_valid !== 1'b1 || bus.mem_addr !== 16'd2)
                        $display("FAIL stall%0d: pix=%0d pv=%b addr=%0d want 30 1 2",
                                 k, bus.pix_out, bus.pix_out_valid, bus.mem_addr);
                    else pass_cnt++;
                    step();
                end
                bus.pix_out_ready = 1'b1;
                #1;
            end
            total_cnt++;
            if (bus.pix_out !== exp[i] || bus.pix_out_valid !== 1'b1 || bus.frame_done !== (i == 3))
                $display("FAIL unload_out%0d: pix=%0d pv=%b fd=%b want %0d 1 %b",
                         i, bus.pix_out, bus.pix_out_valid, bus.frame_done, exp[i], (i == 3));
            else pass_cnt++;
            step();
        end
        bus.pix_out_ready = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.pix_out_valid !== 1'b0 || fd_cnt - fd0 !== 1)
            $display("FAIL unload_end: busy=%b fd=%b pv=%b pulses=%0d want 0 0 0 1",
                     bus.busy, bus.frame_done, bus.pix_out_valid, fd_cnt - fd0);
        else pass_cnt++;
    endtask

    task automatic test_ignore();
        bit done;
        bus.go = 1'b1; bus.dim = 9'd2;
        step();
        bus.go = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.pix_in_ready !== 1'b1 || bus.mem_own !== 1'b1 || bus.mem_addr !== 16'd0)
            $display("FAIL load_start_ignored: ird=%b own=%b addr=%0d want 1 1 0",
                     bus.pix_in_ready, bus.mem_own, bus.mem_addr);
        else pass_cnt++;
        // dim changes after capture must not alter the frame size
        bus.dim = 9'd5;
        for (int i = 0; i < 4; i++) begin
            bus.pix_in = 8'd1 + 8'(i);
            bus.pix_in_valid = 1'b1;
            step();
        end
        bus.pix_in_valid = 1'b0;
        total_cnt++;
        if (bus.ready !== 1'b0 || bus.pix_in_ready !== 1'b0)
            $display("FAIL dim_change_ignored: rdy=%b ird=%b want 0 0", bus.ready, bus.pix_in_ready);
        else pass_cnt++;
        step();
        drain(40, done);
        total_cnt++;
        if (!done || got_q.size() != 4 || got_q[0] !== 8'd1 || got_q[3] !== 8'd4)
            $display("FAIL ignore_frame: done=%b n=%0d want 1 4", done, got_q.size());
        else pass_cnt++;
        bus.pix_out_ready = 1'b0;
    endtask

    task automatic test_dim_bounds();
        bit done;
        int fed, errs;
        bus.go = 1'b1; bus.dim = 9'd0;
        step();
        bus.go = 1'b0;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.pix_in_ready !== 1'b0)
            $display("FAIL dim_zero: busy=%b ird=%b want 0 0", bus.busy, bus.pix_in_ready);
        else pass_cnt++;
        bus.go = 1'b1; bus.dim = 9'd40;
        step();
        bus.go = 1'b0;
        fed = 0;
        while (bus.pix_in_ready === 1'b1 && fed < 1000) begin
            bus.pix_in = 8'(fed);
            bus.pix_in_valid = 1'b1;
            step();
            fed++;
        end
        bus.pix_in_valid = 1'b0;
        total_cnt++;
        if (fed != 784 || last_wr_addr !== 16'd783 || bus.ready !== 1'b0)
            $display("FAIL dim_clamp: pixels=%0d last_addr=%0d rdy=%b want 784 783 0", fed, last_wr_addr, bus.ready);
        else pass_cnt++;
        step();
        drain(2000, done);
        errs = 0;
        foreach (got_q[i]) if (got_q[i] !== 8'(i)) errs++;
        total_cnt++;
        if (!done || got_q.size() != 784 || errs != 0)
            $display("FAIL dim_clamp_unload: done=%b n=%0d errs=%0d want 1 784 0", done, got_q.size(), errs);
        else pass_cnt++;
        bus.pix_out_ready = 1'b0;
        // single-pixel frame: launch immediately after its one write
        load_frame(9'd1, 8'd77, 1);
        total_cnt++;
        if (bus.ready !== 1'b0 || last_wr_addr !== 16'd0 || ram[0] !== 8'd77)
            $display("FAIL dim_one: rdy=%b last_addr=%0d ram0=%0d want 0 0 77", bus.ready, last_wr_addr, ram[0]);
        else pass_cnt++;
        step();
        drain(20, done);
        total_cnt++;
        if (!done || got_q.size() != 1 || got_q[0] !== 8'd77)
            $display("FAIL dim_one_unload: done=%b n=%0d want 1 1", done, got_q.size());
        else pass_cnt++;
        bus.pix_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        bit done;
        load_frame(9'd2, 8'd100, 3);
        rst_n = 1'b1;
        bus.go = 1'b1; bus.start = 1'b1; bus.pix_in_valid = 1'b1; bus.pix_out_ready = 1'b1;
        step();
        total_cnt++;
        if ({bus.pix_in_ready, bus.ready, bus.mem_own, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.pix_out_valid, bus.busy, bus.frame_done, bus.pix_out} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0})
            $display("FAIL midload_reset: ird=%b rdy=%b own=%b we=%b addr=%h wd=%h pv=%b busy=%b fd=%b pix=%h",
                     bus.pix_in_ready, bus.ready, bus.mem_own, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                     bus.pix_out_valid, bus.busy, bus.frame_done, bus.pix_out);
        else pass_cnt++;
        rst_n = 1'b0;
        bus.go = 1'b0; bus.start = 1'b0; bus.pix_in_valid = 1'b0; bus.pix_out_ready = 1'b0;
        step();
        bus.go = 1'b1; bus.dim = 9'd2;
        step();
        bus.go = 1'b0;
        bus.pix_in = 8'd9; bus.pix_in_valid = 1'b1;
        #1;
        total_cnt++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'd0)
            $display("FAIL restart_addr: we=%b addr=%0d want 1 0", bus.mem_we, bus.mem_addr);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus.pix_in = 8'd9 - 8'(i);
            step();
        end
        bus.pix_in_valid = 1'b0;
        step();
        drain(40, done);
        total_cnt++;
        if (!done || got_q.size() != 4 || {got_q[0], got_q[1], got_q[2], got_q[3]} !== {8'd9, 8'd8, 8'd7, 8'd6})
            $display("FAIL restart_frame: done=%b n=%0d want 1 4 (9 8 7 6)", done, got_q.size());
        else pass_cnt++;
        bus.pix_out_ready = 1'b0;
    endtask

    initial begin
        bus.go = 1'b0; bus.dim = '0; bus.pix_in = '0; bus.pix_in_valid = 1'b0;
        bus.start = 1'b0; bus.pix_out_ready = 1'b0;
        test_reset();
        test_load();
        test_unload();
        test_ignore();
        test_dim_bounds();
        test_reset_mid_load();
        total_cnt++;
        if (own_viol != 0) $display("FAIL mem_idle_quiet: violations=%0d want 0", own_viol);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
